// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the in-order pipeline control logic: stall-controller
// FSM encodings, the flush-length limit and the stage-control bundle.
package rv32_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } pipe_state_e;

    // The flush down-counter is 2 bits wide, so at most 3 extra flush cycles.
    localparam int FLUSH_CYCLES_MAX = 3;

    // One bit per pipeline control line, MSB first as listed.
    typedef struct packed {
        logic pc_we;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic id_bubble;
        logic ex_bubble;
        logic if_flush;
    } pipe_ctrl_t;

    // Held in reset: nothing advances, and the IF/ID instruction is zeroed.
    localparam pipe_ctrl_t CTRL_RESET = '{pc_we: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                          ex_mem_en: 1'b0, mem_wb_en: 1'b0, id_bubble: 1'b0,
                                          ex_bubble: 1'b0, if_flush: 1'b1};
    // Data-memory stall: the whole pipe is frozen.
    localparam pipe_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                           ex_mem_en: 1'b0, mem_wb_en: 1'b0, id_bubble: 1'b0,
                                           ex_bubble: 1'b0, if_flush: 1'b0};
    // Taken branch: redirect PC and kill the two younger instructions.
    localparam pipe_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                           ex_mem_en: 1'b1, mem_wb_en: 1'b1, id_bubble: 1'b1,
                                           ex_bubble: 1'b1, if_flush: 1'b1};
    // Load-use: hold PC and IF/ID, push a bubble into EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                             ex_mem_en: 1'b1, mem_wb_en: 1'b1, id_bubble: 1'b1,
                                             ex_bubble: 1'b0, if_flush: 1'b0};
    // Instruction fetch not ready: hold PC, feed a NOP into ID.
    localparam pipe_ctrl_t CTRL_IMEM = '{pc_we: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, mem_wb_en: 1'b1, id_bubble: 1'b0,
                                         ex_bubble: 1'b0, if_flush: 1'b1};
    // Post-branch flush window: everything advances, the fetched word is killed.
    localparam pipe_ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                          ex_mem_en: 1'b1, mem_wb_en: 1'b1, id_bubble: 1'b0,
                                          ex_bubble: 1'b0, if_flush: 1'b1};
    // Normal flow.
    localparam pipe_ctrl_t CTRL_RUN = '{pc_we: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                        ex_mem_en: 1'b1, mem_wb_en: 1'b1, id_bubble: 1'b0,
                                        ex_bubble: 1'b0, if_flush: 1'b0};

    // Clamp a requested flush length into the range the 2-bit counter can hold.
    function automatic logic [1:0] flush_load(input int n);
        if (n <= 0) return 2'd0;
        if (n >= FLUSH_CYCLES_MAX) return 2'(FLUSH_CYCLES_MAX);
        return 2'(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        // NOTE: assigning a default first means every path writes cnt_d, so no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush controller for a 5-stage pipeline. Turns hazard and
// memory-handshake inputs into stage-register enables, bubble and flush
// controls in the same cycle, and counts cycles in which the PC is held.
module pipeline_stall_controller
    import rv32_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_we_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             id_bubble_o,
    output logic             ex_bubble_o,
    output logic             if_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam logic [1:0] FLUSH_LOAD = flush_load(FLUSH_CYCLES);

    pipe_state_e state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    // Hazards seen while the pipe is frozen; EX/ID are held, but a pulsed
    // input must still be honoured once the pipe moves again.
    logic        pend_branch_q, pend_branch_d;
    logic        pend_lu_q, pend_lu_d;
    pipe_ctrl_t  ctrl;

    logic frozen;
    logic branch_eff;
    logic lu_eff;

    // In MEM_WAIT only dmem_ready releases the pipe; elsewhere a fresh
    // unanswered data request freezes it.
    assign frozen     = (state_q == ST_MEM_WAIT) ? ~dmem_ready_i
                                                 : (dmem_req_i & ~dmem_ready_i);
    assign branch_eff = branch_taken_i | pend_branch_q;
    assign lu_eff     = load_use_i | pend_lu_q;

    // State, flush counter and pending-hazard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= 2'd0;
            pend_branch_q <= 1'b0;
            pend_lu_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            pend_branch_q <= pend_branch_d;
            pend_lu_q     <= pend_lu_d;
        end
    end

    // Next-state logic: freeze handling, branch entry/reload and flush countdown.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        pend_branch_d = frozen & branch_eff;
        pend_lu_d     = frozen & lu_eff;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (frozen) begin
                    state_d = ST_MEM_WAIT;
                end else if (branch_eff && (FLUSH_LOAD != 2'd0)) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (frozen) begin
                    state_d = ST_FLUSH;
                end else if (branch_eff) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q <= 2'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 2'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 2'd0;
            end
        endcase
    end

    // Output logic: control lines from state and live inputs, prioritised.
    always_comb begin
        ctrl = CTRL_RESET;
        if (rst_n) begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (frozen)             ctrl = CTRL_FREEZE;
                    else if (branch_eff)    ctrl = CTRL_BRANCH;
                    else if (lu_eff)        ctrl = CTRL_LOAD_USE;
                    else if (!imem_ready_i) ctrl = CTRL_IMEM;
                    else                    ctrl = CTRL_RUN;
                end
                ST_FLUSH: begin
                    ctrl = frozen ? CTRL_FREEZE : CTRL_FLUSH;
                end
                default: begin
                    ctrl = CTRL_RESET;
                end
            endcase
        end
    end

    assign pc_we_o     = ctrl.pc_we;
    assign if_id_en_o  = ctrl.if_id_en;
    assign id_ex_en_o  = ctrl.id_ex_en;
    assign ex_mem_en_o = ctrl.ex_mem_en;
    assign mem_wb_en_o = ctrl.mem_wb_en;
    assign id_bubble_o = ctrl.id_bubble;
    assign ex_bubble_o = ctrl.ex_bubble;
    assign if_flush_o  = ctrl.if_flush;
    assign state_o     = state_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (~ctrl.pc_we),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a stimulus process drives
// inputs and queues the expected response from a behavioural model; a monitor
// compares the DUT outputs against the queue every cycle.
module tb_pipeline_stall_controller;

    localparam int FC      = 2;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_use_i = 1'b0;
    logic          branch_taken_i = 1'b0;
    logic          imem_ready_i = 1'b1;
    logic          dmem_req_i = 1'b0;
    logic          dmem_ready_i = 1'b0;
    logic          cnt_clr_i = 1'b0;
    logic          pc_we_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
    logic          id_bubble_o, ex_bubble_o, if_flush_o;
    logic [CW-1:0] stall_cnt_o;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .FLUSH_CYCLES(FC),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_i    (load_use_i),
        .branch_taken_i(branch_taken_i),
        .imem_ready_i  (imem_ready_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ready_i  (dmem_ready_i),
        .cnt_clr_i     (cnt_clr_i),
        .pc_we_o       (pc_we_o),
        .if_id_en_o    (if_id_en_o),
        .id_ex_en_o    (id_ex_en_o),
        .ex_mem_en_o   (ex_mem_en_o),
        .mem_wb_en_o   (mem_wb_en_o),
        .id_bubble_o   (id_bubble_o),
        .ex_bubble_o   (ex_bubble_o),
        .if_flush_o    (if_flush_o),
        .stall_cnt_o   (stall_cnt_o),
        .state_o       (state_o)
    );

    // ctrl bit order: pc_we, if_id, id_ex, ex_mem, mem_wb, id_bubble, ex_bubble, if_flush
    typedef struct {
        logic [7:0] ctrl;
        int         state;
        int         cnt;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: what the pipeline is doing, in plain terms.
    bit m_mem_wait;    // waiting for data memory
    int m_flush_left;  // flush cycles still owed after a taken branch
    bit m_pend_br;     // branch seen while frozen
    bit m_pend_lu;     // load-use seen while frozen
    int m_stalls;      // cycles with the PC held, saturating

    // One clock of stimulus plus the model's prediction for that cycle.
    task automatic drive(input bit rst, input bit lu, input bit br, input bit imem,
                         input bit dreq, input bit drdy, input bit clr, input string tag);
        exp_t       e;
        logic [7:0] c;
        bit         frozen, b, l;
        @(posedge clk);
        #1;
        rst_n          = rst;
        load_use_i     = lu;
        branch_taken_i = br;
        imem_ready_i   = imem;
        dmem_req_i     = dreq;
        dmem_ready_i   = drdy;
        cnt_clr_i      = clr;
        if (!rst) begin
            c            = 8'b00000_001;
            m_mem_wait   = 1'b0;
            m_flush_left = 0;
            m_pend_br    = 1'b0;
            m_pend_lu    = 1'b0;
            m_stalls     = 0;
            e.state      = 0;
            e.cnt        = 0;
        end else begin
            e.state = m_mem_wait ? 1 : ((m_flush_left > 0) ? 2 : 0);
            e.cnt   = m_stalls;
            frozen  = m_mem_wait ? !drdy : (dreq && !drdy);
            b       = br || m_pend_br;
            l       = lu || m_pend_lu;
            if (frozen) begin
                c         = 8'b00000_000;
                m_pend_br = b;
                m_pend_lu = l;
                if (m_flush_left == 0) m_mem_wait = 1'b1;
            end else begin
                m_pend_br  = 1'b0;
                m_pend_lu  = 1'b0;
                m_mem_wait = 1'b0;
                if (m_flush_left > 0) begin
                    c            = 8'b11111_001;
                    m_flush_left = b ? FC : m_flush_left - 1;
                end else if (b) begin
                    c            = 8'b11111_111;
                    m_flush_left = FC;
                end else if (l) begin
                    c = 8'b00111_100;
                end else if (!imem) begin
                    c = 8'b01111_001;
                end else begin
                    c = 8'b11111_000;
                end
            end
            if (clr) m_stalls = 0;
            else if (!c[7] && m_stalls < CNT_MAX) m_stalls = m_stalls + 1;
        end
        e.ctrl = c;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 1, 0, 0, 0, tag);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pc_we_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
                       id_bubble_o, ex_bubble_o, if_flush_o};
                checks++;
                if (act !== e.ctrl || int'(state_o) != e.state || int'(stall_cnt_o) != e.cnt) begin
                    errors++;
                    $display("FAIL %s @%0t: got ctrl=%b state=%0d cnt=%0d, expected ctrl=%b state=%0d cnt=%0d",
                             e.tag, $time, act, state_o, stall_cnt_o, e.ctrl, e.state, e.cnt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit rst, lu, br, imem, dreq, drdy, clr;

        // Reset held for a few cycles.
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0, "reset");

        // A: single load-use cycle.
        idle(1, "a_idle");
        drive(1, 1, 0, 1, 0, 0, 0, "a_load_use");
        idle(2, "a_after");

        // B: three-cycle data-memory stall, then release.
        drive(1, 0, 0, 1, 0, 0, 1, "b_clr");
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 1, 0, 0, "b_wait");
        drive(1, 0, 0, 1, 1, 1, 0, "b_release");
        idle(2, "b_after");

        // C: branch pulse, two extra flush cycles.
        drive(1, 0, 1, 1, 0, 0, 0, "c_branch");
        idle(4, "c_flush");

        // D: branch held while frozen on data memory.
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 1, 1, 0, 0, "d_frozen");
        drive(1, 0, 1, 1, 1, 1, 0, "d_release");
        idle(4, "d_flush");

        // D2: branch pulsed only while frozen must not be lost.
        drive(1, 0, 0, 1, 1, 0, 0, "d2_enter");
        drive(1, 0, 1, 1, 1, 0, 0, "d2_pulse");
        drive(1, 0, 0, 1, 1, 0, 0, "d2_wait");
        drive(1, 0, 0, 1, 1, 1, 0, "d2_release");
        idle(4, "d2_flush");

        // E: counter saturation and clear-over-increment.
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 0, "e_imem");
        drive(1, 0, 0, 0, 0, 0, 1, "e_clr_inc");
        idle(2, "e_after");

        // F: reset in the middle of the flush window.
        drive(1, 0, 1, 1, 0, 0, 0, "f_branch");
        idle(1, "f_flush");
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 0, 0, 0, "f_reset");
        idle(3, "f_run");

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(99) != 0);
            lu   = ($urandom_range(99) < 15);
            br   = ($urandom_range(99) < 10);
            imem = ($urandom_range(99) < 80);
            dreq = ($urandom_range(99) < 30);
            drdy = ($urandom_range(99) < 50);
            clr  = ($urandom_range(99) < 5);
            drive(rst, lu, br, imem, dreq, drdy, clr, "rand");
        end

        // Let the monitor consume the remaining predictions.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
